// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants for the integer datapath and register file.
package cpu_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] XZR_IDX = 5'd31;

endpackage

// File: rtl/wq_fwd_match.sv
// Youngest-first match of a read index against an age-ordered list of pending writes.
module wq_fwd_match #(
  parameter int unsigned N      = 5,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned DATA_W = 64
) (
  input  logic [N-1:0]             vld_i,
  input  logic [N-1:0][IDX_W-1:0]  idx_i,
  input  logic [N-1:0][DATA_W-1:0] data_i,
  input  logic [IDX_W-1:0]         rd_i,
  output logic                     hit_o,
  output logic [DATA_W-1:0]        data_o
);

  // Slot 0 is the oldest; later matches override earlier ones so the youngest wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (vld_i[k] && (idx_i[k] == rd_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[k];
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// In-order write-back queue feeding the single register-file write port,
// with newest-value forwarding for the two decode read indexes.
module regfile_write_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = XLEN,
  parameter int unsigned IDX_W  = REG_IDX_W
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         AluWr,
  input  logic [IDX_W-1:0]             AluRd,
  input  logic [DATA_W-1:0]            AluData,
  input  logic                         MemWr,
  input  logic [IDX_W-1:0]             MemRd,
  input  logic [DATA_W-1:0]            MemData,
  output logic                         Stall,
  output logic [DATA_W-1:0]            BusW,
  output logic [IDX_W-1:0]             RW,
  output logic                         RegWr,
  input  logic [IDX_W-1:0]             RA,
  input  logic [IDX_W-1:0]             RB,
  output logic [DATA_W-1:0]            FwdA,
  output logic [DATA_W-1:0]            FwdB,
  output logic                         FwdAValid,
  output logic                         FwdBValid,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned N_FWD = DEPTH + 1;
  localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(XZR_IDX);

  logic [DEPTH-1:0][IDX_W-1:0]  idx_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              regwr_q, regwr_d;
  logic [IDX_W-1:0]  rw_q, rw_d;
  logic [DATA_W-1:0] busw_q, busw_d;

  logic              mem_req, alu_req, mem_push, alu_push, pop;
  logic [CNT_W-1:0]  free, n_push;
  logic [PTR_W-1:0]  mem_slot, alu_slot;

  // Free space counts the slot vacated by this edge's pop; ALU is the first to be dropped.
  always_comb begin
    mem_req    = MemWr && (MemRd != ZERO_IDX);
    alu_req    = AluWr && (AluRd != ZERO_IDX);
    pop        = (count_q != '0);
    free       = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
    mem_push   = mem_req && (free != '0);
    alu_push   = alu_req && (free > CNT_W'(mem_push));
    n_push     = CNT_W'(mem_push) + CNT_W'(alu_push);
    mem_slot   = tail_q;
    alu_slot   = tail_q + PTR_W'(mem_push);
    head_d     = head_q + PTR_W'(pop);
    tail_d     = tail_q + PTR_W'(n_push);
    count_d    = count_q + n_push - CNT_W'(pop);
    overflow_d = overflow_q | (mem_req & ~mem_push) | (alu_req & ~alu_push);
    regwr_d    = pop;
    rw_d       = pop ? idx_q[head_q]  : rw_q;
    busw_d     = pop ? data_q[head_q] : busw_q;
  end

  always_ff @(posedge Clk) begin
    if (mem_push) begin
      idx_q[mem_slot]  <= MemRd;
      data_q[mem_slot] <= MemData;
    end
    if (alu_push) begin
      idx_q[alu_slot]  <= AluRd;
      data_q[alu_slot] <= AluData;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      regwr_q    <= 1'b0;
      rw_q       <= '0;
      busw_q     <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      regwr_q    <= regwr_d;
      rw_q       <= rw_d;
      busw_q     <= busw_d;
    end
  end

  // Age-ordered view: the output register is oldest, then queue entries head to tail.
  logic [N_FWD-1:0]             ord_vld;
  logic [N_FWD-1:0][IDX_W-1:0]  ord_idx;
  logic [N_FWD-1:0][DATA_W-1:0] ord_data;

  always_comb begin
    ord_vld[0]  = regwr_q;
    ord_idx[0]  = rw_q;
    ord_data[0] = busw_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      ord_vld[k+1]  = (CNT_W'(k) < count_q);
      ord_idx[k+1]  = idx_q[head_q + PTR_W'(k)];
      ord_data[k+1] = data_q[head_q + PTR_W'(k)];
    end
  end

  logic              hit_a, hit_b;
  logic [DATA_W-1:0] dat_a, dat_b;

  wq_fwd_match #(.N(N_FWD), .IDX_W(IDX_W), .DATA_W(DATA_W)) u_fwd_a (
    .vld_i (ord_vld),
    .idx_i (ord_idx),
    .data_i(ord_data),
    .rd_i  (RA),
    .hit_o (hit_a),
    .data_o(dat_a)
  );

  wq_fwd_match #(.N(N_FWD), .IDX_W(IDX_W), .DATA_W(DATA_W)) u_fwd_b (
    .vld_i (ord_vld),
    .idx_i (ord_idx),
    .data_i(ord_data),
    .rd_i  (RB),
    .hit_o (hit_b),
    .data_o(dat_b)
  );

  assign FwdAValid = hit_a && (RA != ZERO_IDX);
  assign FwdBValid = hit_b && (RB != ZERO_IDX);
  assign FwdA      = FwdAValid ? dat_a : '0;
  assign FwdB      = FwdBValid ? dat_b : '0;

  assign Stall    = (count_q > CNT_W'(DEPTH - 2));
  assign Count    = count_q;
  assign Overflow = overflow_q;
  assign RegWr    = regwr_q;
  assign RW       = rw_q;
  assign BusW     = busw_q;

endmodule
